// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's data-memory port and the responder.
// Both channels transfer on a rising edge where valid & ready are high. valid must not depend on ready. Payload is stable while valid waits.
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_write_en;
  logic [1:0]            i_req_store_type;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_write_data;
  logic                  o_resp_valid;
  logic                  i_resp_ready;
  logic [DATA_WIDTH-1:0] o_resp_read_data;
  logic                  o_resp_err;

  modport slave (
    input  i_req_valid, i_req_write_en, i_req_store_type, i_req_addr, i_req_write_data,
    input  i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_read_data, o_resp_err
  );

  modport master (
    output i_req_valid, i_req_write_en, i_req_store_type, i_req_addr, i_req_write_data,
    output i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_read_data, o_resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: byte-masked stores, right-aligned loads, fixed latency.
// Optional retire counters are enabled with the DMEM_PERF_CNT_EN macro.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                srst,
  data_mem_responder_if.slave bus,
  output logic [1:0]          o_dbg_state
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]         o_rd_count,
  output logic [31:0]         o_wr_count
`endif
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]      idx;
  logic [2:0]            byte_off;
  logic [5:0]            bit_off;
  logic [7:0]            size_mask;
  logic [7:0]            byte_en;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic                  accept;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] rd_shifted;

  assign idx          = bus.i_req_addr[3 +: IDX_W];
  assign byte_off     = bus.i_req_addr[2:0];
  assign bit_off      = {byte_off, 3'b000};
  assign out_of_range = bus.i_req_addr[ADDR_WIDTH-1:3] >= (ADDR_WIDTH-3)'(DEPTH_WORDS);
  assign lane_data    = bus.i_req_write_data << bit_off;
  assign rd_shifted   = mem_q[idx] >> bit_off;
  assign byte_en      = size_mask << byte_off;
  assign accept       = (state_q == IDLE) && bus.i_req_valid;

  always_comb begin
    size_mask  = 8'h01;
    misaligned = 1'b0;
    case (bus.i_req_store_type)
      2'b00: begin size_mask = 8'h01; misaligned = 1'b0;                     end
      2'b01: begin size_mask = 8'h03; misaligned = bus.i_req_addr[0];        end
      2'b10: begin size_mask = 8'h0F; misaligned = |bus.i_req_addr[1:0];     end
      default: begin size_mask = 8'hFF; misaligned = |bus.i_req_addr[2:0];   end
    endcase
  end

  // Access size only describes stores; loads are always a full doubleword shifted down.
  assign req_err = out_of_range | (bus.i_req_write_en & misaligned);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          cnt_d       = 4'd1;
          resp_err_d  = req_err;
          resp_data_d = (req_err || bus.i_req_write_en) ? '0 : rd_shifted;
          mem_we      = bus.i_req_write_en && !req_err;
          state_d     = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // Leaving on the edge where the count has reached LATENCY puts o_resp_valid
        // exactly LATENCY edges after the accept edge.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(LATENCY)) state_d = RESP;
      end
      RESP: begin
        if (bus.i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !srst) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem_q[idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  assign bus.o_req_ready      = (state_q == IDLE);
  assign bus.o_resp_valid     = (state_q == RESP);
  assign bus.o_resp_read_data = resp_data_q;
  assign bus.o_resp_err       = resp_err_q;
  assign o_dbg_state          = state_q;

`ifdef DMEM_PERF_CNT_EN
  logic        resp_wr_q;
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic        retire_ok;

  assign retire_ok = (state_q == RESP) && bus.i_resp_ready && !resp_err_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      resp_wr_q <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      if (accept) resp_wr_q <= bus.i_req_write_en;
      if (retire_ok) begin
        if (resp_wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
        else           rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign o_rd_count = rd_cnt_q;
  assign o_wr_count = wr_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY = 2, DEPTH_WORDS = 512).
// Counter checks are compiled in when DMEM_PERF_CNT_EN is defined.
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();
  logic [1:0] dbg_state;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  data_mem_responder #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH_WORDS(512), .LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
`ifdef DMEM_PERF_CNT_EN
    ,
    .o_rd_count (rd_count),
    .o_wr_count (wr_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
  endtask

  // Ends on the falling edge right after the accept edge.
  task automatic drive_accept(input string tag, input logic we, input logic [1:0] st,
                              input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    chk({tag, " req_ready"}, 64'(bus.o_req_ready), 64'd1);
    bus.i_req_valid      = 1'b1;
    bus.i_req_write_en   = we;
    bus.i_req_store_type = st;
    bus.i_req_addr       = addr;
    bus.i_req_write_data = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic exp_err);
    int lat;
    logic [63:0] exp_data;
    lat = 0;
    while (bus.o_resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    exp_data = exp_q.pop_front();
    chk({tag, " latency"}, 64'(lat), 64'(LAT));
    chk({tag, " data"}, bus.o_resp_read_data, exp_data);
    chk({tag, " err"}, 64'(bus.o_resp_err), 64'(exp_err));
  endtask

  task automatic retire(input string tag);
    bus.i_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_resp_ready = 1'b0;
    chk({tag, " valid after retire"}, 64'(bus.o_resp_valid), 64'd0);
    chk({tag, " ready after retire"}, 64'(bus.o_req_ready), 64'd1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] st,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] exp_data, input logic exp_err);
    drive_accept(tag, we, st, addr, wdata);
    exp_q.push_back(exp_data);
    wait_resp(tag, exp_err);
    retire(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    srst                 = 1'b1;
    bus.i_req_valid      = 1'b0;
    bus.i_req_write_en   = 1'b0;
    bus.i_req_store_type = 2'b00;
    bus.i_req_addr       = '0;
    bus.i_req_write_data = '0;
    bus.i_resp_ready     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;

    chk("reset req_ready", 64'(bus.o_req_ready), 64'd1);
    chk("reset resp_valid", 64'(bus.o_resp_valid), 64'd0);
    chk("reset data", bus.o_resp_read_data, 64'd0);
    chk("reset err", 64'(bus.o_resp_err), 64'd0);
    chk("reset state", 64'(dbg_state), 64'd0);

    // Doubleword store then load
    txn("t1 st D", 1'b1, 2'b11, 64'h10, 64'h1122334455667788, 64'd0, 1'b0);
    txn("t1 ld", 1'b0, 2'b00, 64'h10, 64'd0, 64'h1122334455667788, 1'b0);

    // Byte store uses only the low byte of write data
    txn("t2 st B", 1'b1, 2'b00, 64'h13, 64'hFFFFFFFFFFFFFFAB, 64'd0, 1'b0);
    txn("t2 ld 10", 1'b0, 2'b00, 64'h10, 64'd0, 64'h11223344AB667788, 1'b0);
    txn("t2 ld 13", 1'b0, 2'b00, 64'h13, 64'd0, 64'h00000011223344AB, 1'b0);

    // Misaligned store and out-of-range load
    txn("t3 st W mis", 1'b1, 2'b10, 64'h12, 64'hDEADBEEF, 64'd0, 1'b1);
    txn("t3 ld unchg", 1'b0, 2'b00, 64'h10, 64'd0, 64'h11223344AB667788, 1'b0);
    txn("t3 ld oor", 1'b0, 2'b11, 64'h1000, 64'd0, 64'd0, 1'b1);

    // Halfword into the top lanes, last-word byte store
    txn("hw st", 1'b1, 2'b01, 64'h16, 64'h1234BEEF, 64'd0, 1'b0);
    txn("hw ld 14", 1'b0, 2'b00, 64'h14, 64'd0, 64'h00000000BEEF3344, 1'b0);
    txn("top st D", 1'b1, 2'b11, 64'hFF8, 64'h0102030405060708, 64'd0, 1'b0);
    txn("top st B", 1'b1, 2'b00, 64'hFFF, 64'hEE, 64'd0, 1'b0);
    txn("top ld FFF", 1'b0, 2'b00, 64'hFFF, 64'd0, 64'h00000000000000EE, 1'b0);
    txn("top ld FF8", 1'b0, 2'b00, 64'hFF8, 64'd0, 64'hEE02030405060708, 1'b0);

    // Back-pressure on the response; request pulses during RESP must be ignored
    drive_accept("t4 ld", 1'b0, 2'b00, 64'h10, 64'd0);
    exp_q.push_back(64'hBEEF3344AB667788);
    wait_resp("t4 ld", 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.i_req_valid      = (i % 2 == 0);
      bus.i_req_write_en   = 1'b1;
      bus.i_req_store_type = 2'b11;
      bus.i_req_addr       = 64'h10;
      bus.i_req_write_data = 64'd0;
      @(negedge clk);
      chk("t4 hold valid", 64'(bus.o_resp_valid), 64'd1);
      chk("t4 hold data", bus.o_resp_read_data, 64'hBEEF3344AB667788);
      chk("t4 hold err", 64'(bus.o_resp_err), 64'd0);
      chk("t4 hold req_ready", 64'(bus.o_req_ready), 64'd0);
    end
    bus.i_req_valid = 1'b0;
    retire("t4 ld");
    txn("t4 ld again", 1'b0, 2'b00, 64'h10, 64'd0, 64'hBEEF3344AB667788, 1'b0);

    // Reset while waiting on an accepted store
    drive_accept("t5 st", 1'b1, 2'b11, 64'h30, 64'hCAFEF00D12345678);
    chk("t5 in wait", 64'(dbg_state), 64'd1);
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    chk("t5 req_ready", 64'(bus.o_req_ready), 64'd1);
    chk("t5 resp_valid", 64'(bus.o_resp_valid), 64'd0);
    chk("t5 state", 64'(dbg_state), 64'd0);
    txn("t5 ld", 1'b0, 2'b00, 64'h30, 64'd0, 64'hCAFEF00D12345678, 1'b0);

`ifdef DMEM_PERF_CNT_EN
    do_reset();
    chk("t6 rd zero", 64'(rd_count), 64'd0);
    chk("t6 wr zero", 64'(wr_count), 64'd0);
    txn("t6 ld a", 1'b0, 2'b00, 64'h30, 64'd0, 64'hCAFEF00D12345678, 1'b0);
    txn("t6 st a", 1'b1, 2'b11, 64'h40, 64'h5555AAAA5555AAAA, 64'd0, 1'b0);
    txn("t6 st bad", 1'b1, 2'b01, 64'h41, 64'h77, 64'd0, 1'b1);
    txn("t6 ld b", 1'b0, 2'b00, 64'h10, 64'd0, 64'hBEEF3344AB667788, 1'b0);
    txn("t6 st b", 1'b1, 2'b00, 64'h48, 64'h99, 64'd0, 1'b0);
    txn("t6 ld c", 1'b0, 2'b00, 64'h40, 64'd0, 64'h5555AAAA5555AAAA, 1'b0);
    chk("t6 rd count", 64'(rd_count), 64'd3);
    chk("t6 wr count", 64'(wr_count), 64'd2);
    do_reset();
    chk("t6 rd cleared", 64'(rd_count), 64'd0);
    chk("t6 wr cleared", 64'(wr_count), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
